morse_decoder: RTL

Receive side of the board's Morse link: samples a single on/off Morse level (from the encoder's LED line looped back or from a push-button) and decodes letters A–H, using the same timing the encoder produces. Dot = 1 unit on, dash = 3 units on, intra-letter gap = 1 unit off, letter end = ≥3 units off. Output is a 3-bit letter code with a one-cycle valid strobe, or an error strobe; the block sits between the input pad/switch logic and the HEX/LEDR display logic.

---
 rtl/morse_pkg.sv | 60 ++++++
 rtl/morse_unit_timer.sv | 29 ++
 rtl/morse_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, symbol patterns, timing thresholds and decoder states.
// The (length, pattern) constants are also used by the encoder's signal table.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    typedef logic [2:0] letter_t;

    localparam letter_t LETTER_A = 3'd0;
    localparam letter_t LETTER_B = 3'd1;
    localparam letter_t LETTER_C = 3'd2;
    localparam letter_t LETTER_D = 3'd3;
    localparam letter_t LETTER_E = 3'd4;
    localparam letter_t LETTER_F = 3'd5;
    localparam letter_t LETTER_G = 3'd6;
    localparam letter_t LETTER_H = 3'd7;

    localparam int unsigned DASH_MIN_UNITS   = 3;
    localparam int unsigned LETTER_GAP_UNITS = 3;
    localparam int unsigned MAX_SYMBOLS      = 4;

    // Symbol count plus right-aligned pattern, first symbol in the highest used bit, dash = 1.
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } code_t;

    localparam code_t CODE_A = {3'd2, 4'b0001};
    localparam code_t CODE_B = {3'd4, 4'b1000};
    localparam code_t CODE_C = {3'd4, 4'b1010};
    localparam code_t CODE_D = {3'd3, 4'b0100};
    localparam code_t CODE_E = {3'd1, 4'b0000};
    localparam code_t CODE_F = {3'd4, 4'b0010};
    localparam code_t CODE_G = {3'd3, 4'b0110};
    localparam code_t CODE_H = {3'd4, 4'b0000};

    typedef struct packed {
        logic    hit;
        letter_t code;
    } match_t;

    function automatic match_t resolve(input logic [2:0] cnt, input logic [3:0] sym);
        match_t m;
        m.hit  = 1'b1;
        m.code = LETTER_A;
        case ({cnt, sym})
            CODE_A:  m.code = LETTER_A;
            CODE_B:  m.code = LETTER_B;
            CODE_C:  m.code = LETTER_C;
            CODE_D:  m.code = LETTER_D;
            CODE_E:  m.code = LETTER_E;
            CODE_F:  m.code = LETTER_F;
            CODE_G:  m.code = LETTER_G;
            CODE_H:  m.code = LETTER_H;
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Phase-restartable unit timer: parked at half a unit while held, so the first tick after
// release and every tick after it land mid-unit.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 100_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam logic [27:0] HALF   = 28'(UNIT_CYCLES / 2);
    localparam logic [27:0] RELOAD = 28'(UNIT_CYCLES - 1);

    logic [27:0] count_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset || hold) begin
            count_q <= HALF;
        end else if (count_q == '0) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_q - 28'd1;
        end
    end

    assign tick = !hold && (count_q == '0);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver for letters A..H: synchronises the raw level, samples it once per unit and
// resolves the collected symbols into a letter strobe or an error strobe.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 100_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       busy
);

    logic       sync1_q;
    logic       morse_s;
    logic       tick;
    logic       hold;
    logic       is_dash;
    match_t     match;

    state_t     state_q, state_d;
    logic [3:0] sym_q, sym_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic [2:0] run_q, run_d;
    letter_t    letter_q, letter_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= 1'b0;
            morse_s <= 1'b0;
        end else begin
            sync1_q <= morse_in;
            morse_s <= sync1_q;
        end
    end

    assign hold = (state_q == IDLE);

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .hold    (hold),
        .tick    (tick)
    );

    assign is_dash = (run_q >= 3'(DASH_MIN_UNITS));
    assign match   = resolve(cnt_q, sym_q);

    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        run_d    = run_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (morse_s) begin
                    state_d = MARK;
                    run_d   = 3'd0;
                    sym_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            MARK: begin
                if (tick) begin
                    if (morse_s) begin
                        if (run_q != 3'd7) begin
                            run_d = run_q + 3'd1;
                        end
                    end else begin
                        // Symbols past the fourth are dropped but poison the letter.
                        if (cnt_q < 3'(MAX_SYMBOLS)) begin
                            sym_d = {sym_q[2:0], is_dash};
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = SPACE;
                        run_d   = 3'd1;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (morse_s) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = run_q + 3'd1;
                        if (run_d >= 3'(LETTER_GAP_UNITS)) begin
                            state_d = IDLE;
                            if (match.hit && !ovf_q) begin
                                letter_d = match.code;
                                valid_d  = 1'b1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            sym_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            run_q    <= '0;
            letter_q <= LETTER_A;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sym_q    <= sym_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            run_q    <= run_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign error        = error_q;
    assign busy         = (state_q != IDLE);

endmodule
